// File: rtl/wb_sram_lanes.sv
// Wishbone classic single-port SRAM slave with one RAM array per byte lane,
// a programmable wait-state counter, an out-of-range error response and abort
// handling.
//
// state  | meaning
// -------+----------------------------------------------------------------
// S_IDLE | no transfer in flight; also the forced gap after a termination
// S_WAIT | counting wait states; a dropped strobe aborts without side effects
// S_TERM | ack (or err when out of range) is high for this one cycle
module wb_sram_lanes #(
  parameter int AW          = 15,
  parameter int DW          = 32,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic            clk_i,
  input  logic            nrst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic [DW-1:0]   wb_dat_o,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_stb_i,
  input  logic            wb_cyc_i,
  output logic            wb_ack_o,
  output logic            wb_err_o
);

  localparam int SW  = DW / 8;
  localparam int LB  = $clog2(SW);
  localparam int IW  = AW - LB;
  localparam int RAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW:0] DEPTH_W  = (IW + 1)'(DEPTH);
  localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_TERM = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [3:0]     cnt;
  logic [3:0]     cnt_nxt;
  logic           acc;
  logic           oor;
  logic           go_term;
  logic           wr_en;
  logic           rd_en;
  logic [IW-1:0]  word_idx;
  logic [RAW-1:0] ram_adr;
  logic [DW-1:0]  rd_word;
  logic [DW-1:0]  dat_q;
  logic           ack_q;
  logic           err_q;

  assign acc      = wb_cyc_i & wb_stb_i;
  assign word_idx = wb_adr_i[AW-1:LB];
  assign oor      = ({1'b0, word_idx} >= DEPTH_W);
  assign ram_adr  = RAW'(word_idx);

  // Byte-offset bits never reach the array; keep them visibly consumed.
  if (LB > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^wb_adr_i[LB-1:0];
  end

  // Side effects happen only on the edge that enters S_TERM. Holding off the
  // write while reset is asserted keeps a transfer caught by reset from
  // committing.
  assign wr_en = go_term & wb_we_i & ~oor & nrst_i;
  assign rd_en = go_term & ~wb_we_i & ~oor;

  // Next-state logic: count wait states, abort on dropped strobe.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    go_term   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (acc) begin
          if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_LOAD;
          end else begin
            state_nxt = S_TERM;
            go_term   = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!acc) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt == 4'd0) begin
          state_nxt = S_TERM;
          go_term   = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_TERM: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Termination pulses and read data register, all loaded when entering S_TERM.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= go_term & ~oor;
      err_q <= go_term & oor;
      if (rd_en) begin
        dat_q <= rd_word;
      end
    end
  end

  // One independent array per byte lane; contents survive reset.
  for (genvar k = 0; k < SW; k++) begin : g_lane
    logic [7:0] mem [DEPTH];

    // Lane write, gated by its own select bit.
    always_ff @(posedge clk_i) begin
      if (wr_en && wb_sel_i[k]) begin
        mem[ram_adr] <= wb_dat_i[8*k +: 8];
      end
    end

    assign rd_word[8*k +: 8] = mem[ram_adr];
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;

endmodule

// File: tb/tb_wb_sram_lanes.sv
// Bench for wb_sram_lanes: one instance with no wait states, one with three.
module tb_wb_sram_lanes;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk;
  logic nrst;

  logic [AW-1:0] adr   [2];
  logic [DW-1:0] dat_w [2];
  logic [SW-1:0] sel   [2];
  logic          we    [2];
  logic          stb   [2];
  logic          cyc   [2];
  logic [DW-1:0] dat_r [2];
  logic          ack   [2];
  logic          err   [2];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem_m [int];
  logic [31:0] dat_m [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_sram_lanes #(.AW(AW), .DW(DW), .DEPTH(4096), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .nrst_i(nrst), .wb_adr_i(adr[0]), .wb_dat_i(dat_w[0]),
    .wb_dat_o(dat_r[0]), .wb_sel_i(sel[0]), .wb_we_i(we[0]), .wb_stb_i(stb[0]),
    .wb_cyc_i(cyc[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0])
  );

  wb_sram_lanes #(.AW(AW), .DW(DW), .DEPTH(4096), .WAIT_STATES(3)) dut3 (
    .clk_i(clk), .nrst_i(nrst), .wb_adr_i(adr[1]), .wb_dat_i(dat_w[1]),
    .wb_dat_o(dat_r[1]), .wb_sel_i(sel[1]), .wb_we_i(we[1]), .wb_stb_i(stb[1]),
    .wb_cyc_i(cyc[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int key_of(input int u, input int idx);
    return u * 65536 + idx;
  endfunction

  // One full transfer on instance u, checked against the model; ends with the
  // forced idle cycle so the next call starts from an idle slave.
  task automatic xfer(input int u, input bit w, input logic [AW-1:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    int ws;
    int lat;
    int idx;
    bit is_oor;
    bit got_ack;
    bit got_err;
    logic [31:0] word;
    ws = (u == 0) ? 0 : 3;
    lat = 0;
    got_ack = 1'b0;
    got_err = 1'b0;
    idx = int'(a[AW-1:2]);
    is_oor = (idx >= 4096);
    adr[u] = a; dat_w[u] = d; sel[u] = s; we[u] = w; stb[u] = 1'b1; cyc[u] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack[u] === 1'b1 || err[u] === 1'b1) begin
        lat = i;
        got_ack = ack[u];
        got_err = err[u];
        break;
      end
    end
    stb[u] = 1'b0; cyc[u] = 1'b0;
    check("latency", lat, ws + 1);
    check("ack", {31'd0, got_ack}, {31'd0, !is_oor});
    check("err", {31'd0, got_err}, {31'd0, is_oor});
    if (!is_oor) begin
      if (w) begin
        word = mem_m.exists(key_of(u, idx)) ? mem_m[key_of(u, idx)] : 32'd0;
        for (int k = 0; k < SW; k++)
          if (s[k]) word[8*k +: 8] = d[8*k +: 8];
        mem_m[key_of(u, idx)] = word;
      end else begin
        dat_m[u] = mem_m[key_of(u, idx)];
      end
    end
    check("dat_o", dat_r[u], dat_m[u]);
    @(posedge clk);
    @(negedge clk);
    check("pulse_end", {30'd0, ack[u], err[u]}, 32'd0);
  endtask

  initial begin
    logic [AW-1:0] a;
    int idx;
    int u;
    nrst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      adr[i] = '0; dat_w[i] = '0; sel[i] = '0; we[i] = 1'b0; stb[i] = 1'b0; cyc[i] = 1'b0;
      dat_m[i] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      check("reset_out", {dat_r[i][29:0], ack[i], err[i]}, 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // Known full-word contents for every location used below.
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 9; j++) begin
        idx = (j == 8) ? 4095 : j * 4;
        xfer(i, 1'b1, AW'(idx * 4), $urandom, 4'hF);
      end
    end

    // Full write and read-back, then lane-masked writes.
    xfer(0, 1'b1, 15'h0010, 32'hA1B2C3D4, 4'hF);
    xfer(0, 1'b0, 15'h0010, 32'h0, 4'hF);
    check("rd_full", dat_r[0], 32'hA1B2C3D4);
    xfer(0, 1'b1, 15'h0010, 32'h000000EE, 4'b0001);
    xfer(0, 1'b1, 15'h0010, 32'h55000000, 4'b1000);
    xfer(0, 1'b0, 15'h0010, 32'h0, 4'b0001);
    check("rd_lanes", dat_r[0], 32'h55B2C3EE);

    // Out of range: first word past DEPTH, dat_o must hold.
    xfer(0, 1'b0, 15'h4000, 32'h0, 4'hF);
    check("oor_hold", dat_r[0], 32'h55B2C3EE);
    xfer(1, 1'b1, 15'h4004, 32'hDEADBEEF, 4'hF);

    // Back-to-back reads with strobe held: ack on every other cycle.
    adr[0] = 15'h0010; we[0] = 1'b0; sel[0] = 4'hF; stb[0] = 1'b1; cyc[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("b2b_ack", {31'd0, ack[0]}, {31'd0, (i % 2) == 1});
    end
    stb[0] = 1'b0; cyc[0] = 1'b0;
    check("b2b_dat", dat_r[0], 32'h55B2C3EE);
    @(negedge clk);

    // Abort a wait-state write in cycle 2: no termination, no RAM change.
    xfer(1, 1'b1, 15'h0030, 32'h13572468, 4'hF);
    adr[1] = 15'h0030; dat_w[1] = 32'hFFFFFFFF; sel[1] = 4'hF; we[1] = 1'b1;
    stb[1] = 1'b1; cyc[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    stb[1] = 1'b0; cyc[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("abort_quiet", {30'd0, ack[1], err[1]}, 32'd0);
    end
    xfer(1, 1'b0, 15'h0030, 32'h0, 4'hF);
    check("abort_keep", dat_r[1], 32'h13572468);

    // Reset in the middle of a wait-state write.
    xfer(1, 1'b1, 15'h0020, 32'hCAFEF00D, 4'hF);
    xfer(1, 1'b0, 15'h0020, 32'h0, 4'hF);
    adr[1] = 15'h0020; dat_w[1] = 32'h0BADC0DE; sel[1] = 4'hF; we[1] = 1'b1;
    stb[1] = 1'b1; cyc[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    nrst = 1'b0;
    #1;
    check("rst_async_dat", dat_r[1], 32'd0);
    check("rst_async_hs", {30'd0, ack[1], err[1]}, 32'd0);
    dat_m[0] = 32'd0;
    dat_m[1] = 32'd0;
    @(negedge clk);
    stb[1] = 1'b0; cyc[1] = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    xfer(1, 1'b0, 15'h0020, 32'h0, 4'hF);
    check("rst_keep", dat_r[1], 32'hCAFEF00D);

    // Randomized mix over the initialised pool and the out-of-range region.
    for (int n = 0; n < 200; n++) begin
      u = int'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       idx = 4095;
        1:       idx = int'($urandom_range(4096, 8191));
        default: idx = int'($urandom_range(0, 7)) * 4;
      endcase
      a = AW'(idx * 4 + int'($urandom_range(0, 3)));
      xfer(u, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
